pipe_hazard_ctrl: RTL and testbench

Hazard and stall sequencer for the five-stage CPU pipeline. Each cycle it decides whether the IF/ID register loads, holds, or is overwritten with the NO_OP word (0xF0000000). It drives that register's `data_hazard` and `PC_hazard` inputs, plus the PC-enable and ID/EX, EX/MEM control lines. It resolves load-use stalls, taken-branch and jump flushes, and data-memory wait freezes, and arbitrates between them when they coincide.

---
 rtl/pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and stall sequencer for the five-stage pipeline. Each cycle it decides
// whether IF/ID loads, holds (data_hazard) or takes the NO_OP word (PC_hazard),
// and drives PC enable, ID/EX bubble and EX/MEM hold. It handles load-use
// stalls, taken-branch/jump flushes and data-memory wait freezes.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_rs, id_rt, id_uses_rs/rt     ID-stage source operands
//   id_jump                         ID holds a J-type jump
//   ex_rd, ex_mem_read              EX-stage destination / load flag
//   ex_branch_taken                 EX-stage branch resolved taken
//   dmem_req, dmem_ready            MEM-stage access handshake
//   data_hazard, PC_hazard          IF/ID hold / IF/ID load NO_OP
//   pc_stall, idex_bubble           PC hold / ID/EX bubble
//   exmem_hold                      EX/MEM and MEM/WB hold
//   mem_timeout                     sticky data-memory wait timeout
//   hazard_state                    registered FSM state
//   stall_count, flush_count        perf counters
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating perf
// counters; otherwise both counter ports are tied to 0.
//
// state      | meaning
// RUN        | no hazard sequence in progress
// LOAD_STALL | holding IF/ID and PC for the remaining load-use bubbles
// FLUSH      | loading NO_OPs into IF/ID after a taken branch
// MEM_WAIT   | pipeline frozen on data memory; ret_state_q holds where to resume

module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2,
  parameter int WAIT_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_jump,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        data_hazard,
  output logic        PC_hazard,
  output logic        pc_stall,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic        mem_timeout,
  output logic [1:0]  hazard_state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd3;

  localparam int         LS_M1     = LOAD_STALL_CYCLES - 1;
  localparam int         FL_M1     = FLUSH_CYCLES - 1;
  localparam logic [1:0] LS_RELOAD = LS_M1[1:0];
  localparam logic [1:0] FL_RELOAD = FL_M1[1:0];

  // Wait counter is at least 8 bits, wider only if the timeout needs it.
  localparam int WW_MIN = $clog2(WAIT_TIMEOUT + 1);
  localparam int WW     = (WW_MIN > 8) ? WW_MIN : 8;
  localparam logic [WW:0] WT_VAL = WAIT_TIMEOUT[WW:0];

  logic [1:0]    state_q, state_d;
  logic [1:0]    ret_state_q, ret_state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;

  logic          lu;
  logic          fz;
  logic [1:0]    eff_state;
  logic [WW:0]   wait_inc;
  logic          timeout_hit;

  logic dh_c, ph_c, pcs_c, bub_c, hold_c;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
  assign fz = dmem_req && !dmem_ready;

  // Once a freeze lifts, behave exactly as the interrupted state would.
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_state_q : state_q;

  // Count the current freeze cycle too, so the flag is visible in the cycle
  // the limit is reached rather than one cycle later.
  assign wait_inc    = {1'b0, wait_cnt_q} + {{WW{1'b0}}, 1'b1};
  assign timeout_hit = fz && (wait_inc >= WT_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ret_state_q <= ST_RUN;
      cnt_q       <= 2'd0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      cnt_q       <= cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    cnt_d       = cnt_q;
    if (fz) begin
      state_d = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) ret_state_d = state_q;
    end else if (ex_branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        cnt_d   = FL_RELOAD;
        state_d = ST_FLUSH;
      end else begin
        cnt_d   = 2'd0;
        state_d = ST_RUN;
      end
    end else begin
      case (eff_state)
        ST_LOAD_STALL, ST_FLUSH: begin
          cnt_d   = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          state_d = (cnt_q <= 2'd1) ? ST_RUN : eff_state;
        end
        default: begin
          state_d = ST_RUN;
          if (lu && (LOAD_STALL_CYCLES > 1)) begin
            cnt_d   = LS_RELOAD;
            state_d = ST_LOAD_STALL;
          end
        end
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (fz) wait_cnt_d = (wait_inc > WT_VAL) ? wait_cnt_q : wait_inc[WW-1:0];
    timeout_d = timeout_q || timeout_hit;
  end

  always_comb begin
    dh_c   = 1'b0;
    ph_c   = 1'b0;
    pcs_c  = 1'b0;
    bub_c  = 1'b0;
    hold_c = 1'b0;
    if (fz) begin
      dh_c   = 1'b1;
      pcs_c  = 1'b1;
      hold_c = 1'b1;
    end else if (ex_branch_taken) begin
      ph_c  = 1'b1;
      bub_c = 1'b1;
    end else begin
      case (eff_state)
        ST_LOAD_STALL: begin
          dh_c  = 1'b1;
          pcs_c = 1'b1;
          bub_c = 1'b1;
        end
        ST_FLUSH: ph_c = 1'b1;
        default: begin
          if (lu) begin
            dh_c  = 1'b1;
            pcs_c = 1'b1;
            bub_c = 1'b1;
          end else if (id_jump) begin
            ph_c = 1'b1;
          end
        end
      endcase
    end
  end

  // Mealy outputs are forced low while reset is asserted so an aborted stall
  // or flush leaves no residual bubble.
  assign data_hazard  = rst_n && dh_c;
  assign PC_hazard    = rst_n && ph_c;
  assign pc_stall     = rst_n && pcs_c;
  assign idex_bubble  = rst_n && bub_c;
  assign exmem_hold   = rst_n && hold_c;
  assign mem_timeout  = rst_n && (timeout_q || timeout_hit);
  assign hazard_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (pc_stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
    if (PC_hazard && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = 16'd0;
  assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, id_jump;
  logic        ex_mem_read, ex_branch_taken, dmem_req, dmem_ready;

  logic        a_dh, a_ph, a_pcs, a_bub, a_hold, a_to;
  logic [1:0]  a_st;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_dh, b_ph, b_pcs, b_bub, b_hold, b_to;
  logic [1:0]  b_st;
  logic [15:0] b_scnt, b_fcnt;

  int n_total = 0;
  int n_bad   = 0;

  // dut_a: single-cycle load stall; dut_b: three-cycle load stall.
  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .WAIT_TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .data_hazard(a_dh), .PC_hazard(a_ph), .pc_stall(a_pcs), .idex_bubble(a_bub),
    .exmem_hold(a_hold), .mem_timeout(a_to), .hazard_state(a_st),
    .stall_count(a_scnt), .flush_count(a_fcnt)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .WAIT_TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .data_hazard(b_dh), .PC_hazard(b_ph), .pc_stall(b_pcs), .idex_bubble(b_bub),
    .exmem_hold(b_hold), .mem_timeout(b_to), .hazard_state(b_st),
    .stall_count(b_scnt), .flush_count(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      clr();
    end
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt);
    clr();
    ex_mem_read = 1'b1; ex_rd = rd;
    id_rs = rs; id_uses_rs = urs;
    id_rt = rt; id_uses_rt = urt;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #2;
    chk("rst_dh", {31'd0, a_dh}, 32'd0);
    chk("rst_st", {30'd0, a_st}, 32'd0);
    // Reset must mask a load-use pattern on the inputs.
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk("rst_outs", {26'd0, a_dh, a_ph, a_pcs, a_bub, a_hold, a_to}, 32'd0);
    chk("rst_cnt", {a_scnt, a_fcnt}, 32'd0);
    clr();
    cyc(); cyc();
    rst_n = 1'b1;
    idle(2);

    // Load-use via rs: 1 cycle on dut_a, 3 cycles on dut_b.
    cyc(); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    mid();
    chk("lu_a_c1", {29'd0, a_dh, a_pcs, a_bub}, 32'h7);
    chk("lu_a_c1_ph", {31'd0, a_ph}, 32'd0);
    chk("lu_b_c1", {29'd0, b_dh, b_pcs, b_bub}, 32'h7);
    cyc(); clr();
    mid();
    chk("lu_a_c2", {29'd0, a_dh, a_pcs, a_bub}, 32'h0);
    chk("lu_b_c2", {27'd0, b_st, b_dh, b_pcs, b_bub}, 32'hF);
    cyc(); mid();
    chk("lu_b_c3", {27'd0, b_st, b_dh, b_pcs, b_bub}, 32'hF);
    cyc(); mid();
    chk("lu_b_c4", {27'd0, b_st, b_dh, b_pcs, b_bub}, 32'h0);
    idle(2);

    // ex_rd = 0 never stalls; unused operand never stalls; rt match stalls.
    cyc(); set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    mid();
    chk("lu_r0", {29'd0, a_dh, a_pcs, a_bub}, 32'h0);
    cyc(); set_lu(5'd9, 5'd9, 1'b0, 5'd3, 1'b1);
    mid();
    chk("lu_unused", {29'd0, a_dh, a_pcs, a_bub}, 32'h0);
    cyc(); set_lu(5'd7, 5'd2, 1'b1, 5'd7, 1'b1);
    mid();
    chk("lu_rt", {29'd0, a_dh, a_pcs, a_bub}, 32'h7);
    cyc(); set_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    ex_mem_read = 1'b0;
    mid();
    chk("lu_noload", {29'd0, a_dh, a_pcs, a_bub}, 32'h0);
    idle(4);

    // Taken branch: two NO_OPs, bubble only in the first.
    cyc(); clr(); ex_branch_taken = 1'b1;
    mid();
    chk("br_c1", {27'd0, a_st, a_ph, a_bub, a_pcs}, {27'd0, 2'd0, 3'b110});
    cyc(); clr();
    mid();
    chk("br_c2", {27'd0, a_st, a_ph, a_bub, a_pcs}, {27'd0, 2'd2, 3'b100});
    cyc(); mid();
    chk("br_c3", {27'd0, a_st, a_ph, a_bub, a_pcs}, 32'd0);
    idle(2);

    // Jump: one NO_OP, no bubble; ignored under a load-use stall.
    cyc(); clr(); id_jump = 1'b1;
    mid();
    chk("jmp_c1", {28'd0, a_ph, a_bub, a_pcs, a_dh}, 32'h8);
    cyc(); clr();
    mid();
    chk("jmp_c2", {31'd0, a_ph}, 32'd0);
    cyc(); set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); id_jump = 1'b1;
    mid();
    chk("jmp_lu", {30'd0, a_ph, a_dh}, 32'h1);
    idle(4);

    // Branch beats load-use.
    cyc(); set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0); ex_branch_taken = 1'b1;
    mid();
    chk("br_lu", {29'd0, a_ph, a_dh, a_bub}, 32'h5);
    chk("br_lu_b", {29'd0, b_ph, b_dh, b_bub}, 32'h5);
    idle(4);

    // Freeze for 3 cycles entering FLUSH with cnt = 1.
    cyc(); clr(); ex_branch_taken = 1'b1;
    mid();
    chk("fz_br", {31'd0, a_ph}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); clr(); dmem_req = 1'b1; dmem_ready = 1'b0;
      mid();
      chk($sformatf("fz_hold%0d", i), {27'd0, a_pcs, a_dh, a_hold, a_ph, a_bub}, 32'h1C);
      chk($sformatf("fz_st%0d", i), {30'd0, a_st}, (i == 0) ? 32'd2 : 32'd3);
      chk($sformatf("fz_to%0d", i), {31'd0, a_to}, 32'd0);
    end
    cyc(); clr(); dmem_req = 1'b1; dmem_ready = 1'b1;
    mid();
    chk("fz_resume", {28'd0, a_ph, a_pcs, a_hold, a_bub}, 32'h8);
    chk("fz_resume_st", {30'd0, a_st}, 32'd3);
    cyc(); clr();
    mid();
    chk("fz_done", {29'd0, a_ph, a_st}, 32'd0);
    idle(2);

    // Timeout: 6-cycle freeze, flag rises in cycle 4 and sticks.
    for (int i = 1; i <= 6; i++) begin
      cyc(); clr(); dmem_req = 1'b1;
      mid();
      chk($sformatf("to_c%0d", i), {31'd0, a_to}, (i >= 4) ? 32'd1 : 32'd0);
    end
    idle(2);
    mid();
    chk("to_sticky", {30'd0, a_to, a_pcs}, 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("to_rst", {31'd0, a_to}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    idle(2);

    // Reset in the second cycle of a 3-cycle load stall.
    cyc(); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    mid();
    chk("rs_b_c1", {31'd0, b_dh}, 32'd1);
    cyc(); clr();
    mid();
    chk("rs_b_c2", {29'd0, b_st, b_dh}, 32'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_b_outs", {26'd0, b_dh, b_ph, b_pcs, b_bub, b_hold, b_to}, 32'd0);
    chk("rs_b_st", {30'd0, b_st}, 32'd0);
    chk("rs_b_scnt", {16'd0, b_scnt}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc(); mid();
    chk("rs_b_after", {29'd0, b_st, b_dh}, 32'd0);

    // Perf counters: one load stall, then one jump, on dut_a.
    cyc(); set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    cyc(); clr(); id_jump = 1'b1;
    cyc(); clr();
    mid();
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_a", {a_scnt, a_fcnt}, {16'd1, 16'd1});
`else
    chk("perf_a", {a_scnt, a_fcnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
